// File: rtl/fu_cdb_arbiter.sv
// Shares one CDB write port between NUM_REQ multi-cycle FUs using reserved per-requester result FIFOs.
// Define FU_CDB_ARB_FIXED_PRIO_EN to use lowest-index-wins arbitration instead of round-robin.
module fu_cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 2,
    parameter int DATA_W  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         issue,
    input  logic [NUM_REQ-1:0]         fu_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  fu_data,
    output logic [NUM_REQ-1:0]         fu_ready,
    output logic                       cdb_valid,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src,
    output logic                       proto_err
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem    [NUM_REQ][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_REQ];
    logic [PTR_W-1:0]  rd_ptr [NUM_REQ];
    logic [CNT_W-1:0]  cnt    [NUM_REQ];
    logic [CNT_W-1:0]  res    [NUM_REQ];

    logic [NUM_REQ-1:0] take;
    logic [NUM_REQ-1:0] consume;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] bad_issue;
    logic [NUM_REQ-1:0] bad_valid;
    logic               gnt_valid;
    logic [SRC_W-1:0]   gnt_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FU_CDB_ARB_FIXED_PRIO_EN
`else
    // Index of the last winner; the search starts one past it.
    logic [SRC_W-1:0] rr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= SRC_W'(NUM_REQ - 1);
        end else if (cdb_valid) begin
            rr <= gnt_idx;
        end
    end
`endif

    // Issue gating counts both buffered and still-in-flight results.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            fu_ready[i] = ({1'b0, cnt[i]} + {1'b0, res[i]}) < (CNT_W + 1)'(DEPTH);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            take[i]      = !flush && issue[i] && fu_ready[i];
            // A result arriving with its own same-cycle issue consumes that new reservation.
            consume[i]   = !flush && fu_valid[i] && (res[i] != '0 || (issue[i] && fu_ready[i]));
            push[i]      = !flush && fu_valid[i] && (cnt[i] != CNT_FULL || pop[i]);
            bad_issue[i] = !flush && issue[i] && !fu_ready[i];
            bad_valid[i] = !flush && fu_valid[i] && (res[i] == '0) && !issue[i];
        end
    end

    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default before the search so no latch is inferred.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FU_CDB_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr) + 1 + k) % NUM_REQ;
`endif
            if (!gnt_valid && cnt[SRC_W'(idx)] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        cdb_valid = gnt_valid && !flush;
        cdb_src   = cdb_valid ? gnt_idx : '0;
        cdb_data  = cdb_valid ? mem[gnt_idx][rd_ptr[gnt_idx]] : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = cdb_valid && (gnt_idx == SRC_W'(i));
        end
    end

    // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
                res[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                if (push[i] && !pop[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
                if (take[i] && !consume[i]) begin
                    res[i] <= res[i] + 1'b1;
                end else if (consume[i] && !take[i]) begin
                    res[i] <= res[i] - 1'b1;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; occupancy and pointers gate every read of it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (|(bad_issue | bad_valid)) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Directed self-checking bench for fu_cdb_arbiter (NUM_REQ=4, DEPTH=2, DATA_W=64).
// Honours FU_CDB_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_fu_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 2;
    localparam int DATA_W  = 64;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [NUM_REQ-1:0]        issue;
    logic [NUM_REQ-1:0]        fu_valid;
    logic [NUM_REQ*DATA_W-1:0] fu_data;
    logic [NUM_REQ-1:0]        fu_ready;
    logic                      cdb_valid;
    logic [DATA_W-1:0]         cdb_data;
    logic [1:0]                cdb_src;
    logic                      proto_err;

    int checks = 0;
    int errors = 0;
    int exp_src [3];

    fu_cdb_arbiter #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .issue     (issue),
        .fu_valid  (fu_valid),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and return the inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        issue    = '0;
        fu_valid = '0;
        flush    = 1'b0;
        fu_data  = '0;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        fu_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef FU_CDB_ARB_FIXED_PRIO_EN
        exp_src = '{0, 2, 3};
`else
        exp_src = '{2, 3, 0};
`endif
        rst = 1'b1; flush = 1'b0; issue = '0; fu_valid = '0; fu_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_valid", cdb_valid, 0);
        check("rst_data",  cdb_data, 0);
        check("rst_src",   cdb_src, 0);
        check("rst_err",   proto_err, 0);
        check("rst_ready", fu_ready, 4'hF);

        // Single path: issue c0, result c3, visible on CDB at c4 only.
        next_cycle(); issue[1] = 1'b1; #1;
        check("t1_rdy_c0", fu_ready[1], 1);
        next_cycle(); #1;
        check("t1_rdy_c1", fu_ready, 4'hF);
        check("t1_vld_c1", cdb_valid, 0);
        next_cycle(); #1;
        check("t1_vld_c2", cdb_valid, 0);
        next_cycle(); fu_valid[1] = 1'b1; set_data(1, 64'hA5); #1;
        check("t1_vld_c3", cdb_valid, 0);
        next_cycle(); #1;
        check("t1_vld_c4",  cdb_valid, 1);
        check("t1_src_c4",  cdb_src, 1);
        check("t1_data_c4", cdb_data, 64'hA5);
        check("t1_rdy_c4",  fu_ready, 4'hF);
        next_cycle(); #1;
        check("t1_vld_c5",  cdb_valid, 0);
        check("t1_data_c5", cdb_data, 0);
        check("t1_src_c5",  cdb_src, 0);
        check("t1_err",     proto_err, 0);

        // Round-robin: FIFOs 0, 2, 3 loaded together (last winner was 1).
        next_cycle(); issue = 4'b1101; #1;
        check("t2_rdy", fu_ready, 4'hF);
        next_cycle(); fu_valid = 4'b1101;
        set_data(0, 64'h10); set_data(2, 64'h12); set_data(3, 64'h13); #1;
        check("t2_vld_push", cdb_valid, 0);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); #1;
            check($sformatf("t2_vld%0d", k), cdb_valid, 1);
            check($sformatf("t2_src%0d", k), cdb_src, exp_src[k]);
            check($sformatf("t2_data%0d", k), cdb_data, 64'h10 + exp_src[k]);
        end
        next_cycle(); #1;
        check("t2_vld_end",  cdb_valid, 0);
        check("t2_data_end", cdb_data, 0);
        check("t2_err",      proto_err, 0);

        // Full reservations, then push while requester 0 is being granted.
        next_cycle(); issue[0] = 1'b1; #1;
        check("t3_rdy_a", fu_ready[0], 1);
        next_cycle(); issue[0] = 1'b1; #1;
        check("t3_rdy_b", fu_ready[0], 1);
        next_cycle(); fu_valid[0] = 1'b1; set_data(0, 64'h20); #1;
        check("t3_full", fu_ready[0], 0);
        next_cycle(); fu_valid[0] = 1'b1; set_data(0, 64'h21); #1;
        check("t3_vld_a",  cdb_valid, 1);
        check("t3_data_a", cdb_data, 64'h20);
        check("t3_rdy_c",  fu_ready[0], 0);
        next_cycle(); #1;
        check("t3_data_b", cdb_data, 64'h21);
        check("t3_src_b",  cdb_src, 0);
        check("t3_rdy_d",  fu_ready[0], 1);
        check("t3_err",    proto_err, 0);
        next_cycle(); #1;
        check("t3_vld_end", cdb_valid, 0);
        check("t3_rdy_end", fu_ready, 4'hF);

        // Issue while not ready: flagged, reservation not taken.
        next_cycle(); issue[2] = 1'b1;
        next_cycle(); issue[2] = 1'b1;
        next_cycle(); issue[2] = 1'b1; #1;
        check("t4_rdy0", fu_ready[2], 0);
        check("t4_err0", proto_err, 0);
        next_cycle(); fu_valid[2] = 1'b1; set_data(2, 64'h31); #1;
        check("t4_err1", proto_err, 1);
        check("t4_rdy1", fu_ready[2], 0);
        next_cycle(); fu_valid[2] = 1'b1; set_data(2, 64'h32); #1;
        check("t4_src1",  cdb_src, 2);
        check("t4_data1", cdb_data, 64'h31);
        next_cycle(); #1;
        check("t4_data2", cdb_data, 64'h32);
        check("t4_rdy2",  fu_ready[2], 1);
        next_cycle(); #1;
        check("t4_vld_end", cdb_valid, 0);

        // Flush with 3 buffered and 2 reserved, plus a result in the flush cycle.
        next_cycle(); issue = 4'b1111;
        next_cycle(); issue = 4'b1000; fu_valid = 4'b0111;
        set_data(0, 64'h40); set_data(1, 64'h41); set_data(2, 64'h42); #1;
        check("t5_vld_pre", cdb_valid, 0);
        next_cycle(); flush = 1'b1; fu_valid[0] = 1'b1; set_data(0, 64'h99); #1;
        check("t5_rdy_pre", fu_ready, 4'h7);
        check("t5_vld_c0",  cdb_valid, 0);
        next_cycle(); #1;
        check("t5_vld_c1",  cdb_valid, 0);
        check("t5_rdy_c1",  fu_ready, 4'hF);
        check("t5_data_c1", cdb_data, 0);
        next_cycle(); #1;
        check("t5_vld_c2", cdb_valid, 0);

        // Reset with full FIFOs.
        next_cycle(); issue = 4'b1111;
        next_cycle(); issue = 4'b1111; fu_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 64'h50 + i);
        next_cycle(); fu_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 64'h60 + i);
        #1;
        check("t6_vld_pre", cdb_valid, 1);
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; #1;
        check("t6_vld",   cdb_valid, 0);
        check("t6_data",  cdb_data, 0);
        check("t6_src",   cdb_src, 0);
        check("t6_err",   proto_err, 0);
        check("t6_ready", fu_ready, 4'hF);
        next_cycle(); #1;
        check("t6_vld_b", cdb_valid, 0);

        // Unreserved results: flagged but still buffered; first grant after reset favours 0.
        next_cycle(); fu_valid = 4'b1001; set_data(0, 64'h70); set_data(3, 64'h77); #1;
        check("t7_err0", proto_err, 0);
        check("t7_vld0", cdb_valid, 0);
        next_cycle(); #1;
        check("t7_err1",  proto_err, 1);
        check("t7_src1",  cdb_src, 0);
        check("t7_data1", cdb_data, 64'h70);
        next_cycle(); #1;
        check("t7_src2",  cdb_src, 3);
        check("t7_data2", cdb_data, 64'h77);
        next_cycle(); #1;
        check("t7_vld3", cdb_valid, 0);
        check("t7_err3", proto_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
